morph_kernel_ctrl: RTL and testbench
====================================

MORPH_KERNEL_CTRL -- requirements
Module: morph_kernel_ctrl

Interface
REQ-001 The block SHALL have parameter KERNEL_WIDTH, default 71, giving the number of kernel coefficients.
REQ-002 The block SHALL have parameter KERNEL_DATA_WIDTH, default 8, giving the signed coefficient width; AW = $clog2(KERNEL_WIDTH).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cfg_tdata  in  KERNEL_DATA_WIDTH  signed coefficient, index order 0..KERNEL_WIDTH-1.
REQ-006 cfg_tvalid  in  1  coefficient beat valid.
REQ-007 cfg_tlast  in  1  marks the final beat of a kernel load.
REQ-008 cfg_tready  out  1  coefficient beat accepted when high with cfg_tvalid.
REQ-009 busy_erode, busy_dilate  in  1 each  the owning filter core is not idle.
REQ-010 core_hold  out  1  integrator ANDs ~core_hold into each core's axis_in_tvalid.
REQ-011 ero_lut_address, dil_lut_address  in  AW each  kernel read addresses from the two cores.
REQ-012 ero_lut_data, dil_lut_data  out  KERNEL_DATA_WIDTH each  signed coefficient at the requested address.
REQ-013 bank_sel  out  1  index of the active bank.
REQ-014 swap_done  out  1  one-cycle pulse on bank swap.
REQ-015 cfg_error  out  1  sticky framing-error flag.

Function
REQ-016 The block SHALL hold two banks of KERNEL_WIDTH coefficients; the active bank is bank[bank_sel], the shadow bank is bank[~bank_sel].
REQ-017 Read ports SHALL be combinational from the active bank: zero-cycle latency, independent of the FSM, with both ports readable in the same cycle.
REQ-018 A read address >= KERNEL_WIDTH SHALL return 0.
REQ-019 The FSM SHALL have the states ST_LOAD, ST_WAIT_IDLE and ST_SWAP.
REQ-020 ST_LOAD SHALL drive cfg_tready=1 and core_hold=0; each accepted beat writes the shadow bank at wr_idx, then wr_idx increments.
REQ-021 Accepted beat with wr_idx==KERNEL_WIDTH-1 and cfg_tlast=1 SHALL set wr_idx=0 and move the FSM to ST_WAIT_IDLE.
REQ-022 Accepted beat with cfg_tlast=1 and wr_idx<KERNEL_WIDTH-1 SHALL set cfg_error, set wr_idx=0, and keep the FSM in ST_LOAD with no swap.
REQ-023 Accepted beat with wr_idx==KERNEL_WIDTH-1 and cfg_tlast=0 SHALL set cfg_error, set wr_idx=0, and keep the FSM in ST_LOAD with no swap.
REQ-024 A partially written shadow bank SHALL never become active.
REQ-025 ST_WAIT_IDLE SHALL drive cfg_tready=0 and core_hold=1.
REQ-026 ST_WAIT_IDLE SHALL go to ST_SWAP in the first cycle busy_erode==0 and busy_dilate==0 are both sampled, and stay otherwise with no timeout.
REQ-027 ST_SWAP SHALL last exactly one cycle with cfg_tready=0, core_hold=1 and swap_done=1.
REQ-028 At the ST_SWAP clock edge, bank_sel SHALL toggle and the FSM SHALL return to ST_LOAD.
REQ-029 New coefficients SHALL appear on the read ports in the first cycle after ST_SWAP.
REQ-030 swap_done SHALL be 0 in all states other than ST_SWAP.
REQ-031 cfg_error SHALL be cleared only by the next correctly framed load reaching ST_SWAP, or by reset.
REQ-032 Coefficients SHALL be stored unmodified, with no sign extension or saturation.

Reset
REQ-033 While reset=1 the block SHALL force: FSM=ST_LOAD, wr_idx=0, bank_sel=0, both banks all zero, cfg_error=0, swap_done=0.
REQ-034 The corresponding outputs in the cycle after reset deasserts SHALL be cfg_tready=1, core_hold=0, and 0 on both LUT data ports.
REQ-035 Reset SHALL take priority over any simultaneous cfg beat; reset asserted during ST_LOAD, ST_WAIT_IDLE or ST_SWAP SHALL discard the partial load and cancel any pending swap.

Verification
REQ-036 Load 71 beats of value k-35 (k=0..70), tlast on beat 70, both cores idle -> ST_WAIT_IDLE for 1 cycle, swap_done pulses once, bank_sel=1; then address 0 reads -35 and address 70 reads 35 on both ports.
REQ-037 Valid load with busy_erode held high for 20 cycles -> core_hold=1 and cfg_tready=0 throughout, bank_sel unchanged; swap occurs in the cycle after busy_erode falls.
REQ-038 tlast on beat 10 -> cfg_error=1, no swap, reads still return the old bank; a following correct 71-beat load -> swap occurs and cfg_error=0.
REQ-039 72 beats with no tlast -> cfg_error set at beat 71, wr_idx wraps, beat 72 is written to index 0, no swap.
REQ-040 Reset asserted in ST_WAIT_IDLE -> bank_sel=0, all reads 0, cfg_tready=1 next cycle, no swap_done.
REQ-041 ero_lut_address=80 and dil_lut_address=3 in the same cycle -> ero_lut_data=0 and dil_lut_data=active coefficient 3.

Source files
------------

// File: rtl/morph_kernel_ctrl_if.sv
// Coefficient load stream into morph_kernel_ctrl.
// The master drives beats and the slave returns tready.
interface morph_kernel_ctrl_if #(
    parameter int unsigned KERNEL_DATA_WIDTH = 8
);
    logic signed [KERNEL_DATA_WIDTH-1:0] cfg_tdata;
    logic                                cfg_tvalid;
    logic                                cfg_tlast;
    logic                                cfg_tready;

    modport master (
        output cfg_tdata,
        output cfg_tvalid,
        output cfg_tlast,
        input  cfg_tready
    );

    modport slave (
        input  cfg_tdata,
        input  cfg_tvalid,
        input  cfg_tlast,
        output cfg_tready
    );
endinterface

// File: rtl/morph_kernel_ctrl.sv
// Double-buffered kernel coefficient store shared by the erode and dilate cores.
// Loads fill the shadow bank, and the banks swap only once both cores are idle.
module morph_kernel_ctrl #(
    parameter int unsigned KERNEL_WIDTH      = 71,
    parameter int unsigned KERNEL_DATA_WIDTH = 8,
    localparam int unsigned AW = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    morph_kernel_ctrl_if.slave                  cfg,
    input  logic                                busy_erode,
    input  logic                                busy_dilate,
    output logic                                core_hold,
    input  logic [AW-1:0]                       ero_lut_address,
    input  logic [AW-1:0]                       dil_lut_address,
    output logic signed [KERNEL_DATA_WIDTH-1:0] ero_lut_data,
    output logic signed [KERNEL_DATA_WIDTH-1:0] dil_lut_data,
    output logic                                bank_sel,
    output logic                                swap_done,
    output logic                                cfg_error
);
    typedef enum logic [1:0] {StLoad, StWaitIdle, StSwap} state_e;

    localparam logic [AW-1:0] IdxLast = AW'(KERNEL_WIDTH - 1);
    localparam logic [AW:0]   KwExt   = (AW + 1)'(KERNEL_WIDTH);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic          bank_sel_q, bank_sel_d;
    logic          err_q, err_d;
    logic          bank_we;
    logic          swap_pulse;

    logic signed [KERNEL_DATA_WIDTH-1:0] bank_q [2][KERNEL_WIDTH];

    always_comb begin
        state_d        = state_q;
        wr_idx_d       = wr_idx_q;
        bank_sel_d     = bank_sel_q;
        err_d          = err_q;
        bank_we        = 1'b0;
        swap_pulse     = 1'b0;
        cfg.cfg_tready = 1'b0;
        core_hold      = 1'b0;
        unique case (state_q)
            StLoad: begin
                cfg.cfg_tready = 1'b1;
                if (cfg.cfg_tvalid) begin
                    bank_we = 1'b1;
                    if (wr_idx_q == IdxLast && cfg.cfg_tlast) begin
                        wr_idx_d = '0;
                        state_d  = StWaitIdle;
                    end else if (wr_idx_q == IdxLast || cfg.cfg_tlast) begin
                        // Misframed load: restart at index 0, shadow bank stays unpublished.
                        wr_idx_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        wr_idx_d = wr_idx_q + AW'(1);
                    end
                end
            end
            StWaitIdle: begin
                core_hold = 1'b1;
                if (!busy_erode && !busy_dilate) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                core_hold  = 1'b1;
                swap_pulse = 1'b1;
                bank_sel_d = ~bank_sel_q;
                err_d      = 1'b0;
                state_d    = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StLoad;
            wr_idx_q   <= '0;
            bank_sel_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            bank_sel_q <= bank_sel_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(KERNEL_WIDTH); i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (bank_we) begin
            bank_q[~bank_sel_q][wr_idx_q] <= cfg.cfg_tdata;
        end
    end

    always_comb begin
        ero_lut_data = '0;
        dil_lut_data = '0;
        if ({1'b0, ero_lut_address} < KwExt) begin
            ero_lut_data = bank_q[bank_sel_q][ero_lut_address];
        end
        if ({1'b0, dil_lut_address} < KwExt) begin
            dil_lut_data = bank_q[bank_sel_q][dil_lut_address];
        end
    end

    // A swap caught by a synchronous reset never reports completion.
    assign swap_done = swap_pulse & ~reset;
    assign bank_sel  = bank_sel_q;
    assign cfg_error = err_q;
endmodule

// File: tb/tb_morph_kernel_ctrl.sv
// Directed bench for morph_kernel_ctrl: bank swaps, idle wait, framing errors,
// out-of-range reads and reset in mid-load or mid-swap.
module tb_morph_kernel_ctrl;
    localparam int unsigned Kw = 71;
    localparam int unsigned Dw = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              busy_erode;
    logic              busy_dilate;
    logic              core_hold;
    logic [6:0]        ero_addr;
    logic [6:0]        dil_addr;
    logic signed [7:0] ero_data;
    logic signed [7:0] dil_data;
    logic              bank_sel;
    logic              swap_done;
    logic              cfg_error;

    int total = 0;
    int bad   = 0;

    morph_kernel_ctrl_if #(.KERNEL_DATA_WIDTH(Dw)) cfg_if ();

    morph_kernel_ctrl #(
        .KERNEL_WIDTH      (Kw),
        .KERNEL_DATA_WIDTH (Dw)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cfg             (cfg_if),
        .busy_erode      (busy_erode),
        .busy_dilate     (busy_dilate),
        .core_hold       (core_hold),
        .ero_lut_address (ero_addr),
        .dil_lut_address (dil_addr),
        .ero_lut_data    (ero_data),
        .dil_lut_data    (dil_data),
        .bank_sel        (bank_sel),
        .swap_done       (swap_done),
        .cfg_error       (cfg_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int data, input logic last);
        cfg_if.cfg_tvalid = 1'b1;
        cfg_if.cfg_tdata  = 8'(data);
        cfg_if.cfg_tlast  = last;
        tick();
        cfg_if.cfg_tvalid = 1'b0;
        cfg_if.cfg_tlast  = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int addr, input int exp);
        ero_addr = 7'(addr);
        dil_addr = 7'(addr);
        #1;
        check({tag, "_ero"}, ero_data, exp);
        check({tag, "_dil"}, dil_data, exp);
    endtask

    // Full correctly framed load with value k-35 at index k.
    task automatic load_ramp();
        for (int k = 0; k < int'(Kw); k++) begin
            beat(k - 35, k == int'(Kw) - 1);
        end
    endtask

    initial begin
        reset             = 1'b1;
        busy_erode        = 1'b0;
        busy_dilate       = 1'b0;
        ero_addr          = '0;
        dil_addr          = '0;
        cfg_if.cfg_tvalid = 1'b0;
        cfg_if.cfg_tlast  = 1'b0;
        cfg_if.cfg_tdata  = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_tready", cfg_if.cfg_tready, 1);
        check("rst_hold", core_hold, 0);
        check("rst_bank", bank_sel, 0);
        check("rst_err", cfg_error, 0);
        check("rst_swap", swap_done, 0);
        read_chk("rst_rd0", 0, 0);
        read_chk("rst_rd70", 70, 0);
        tick();

        // Basic load and swap with both cores idle.
        load_ramp();
        check("w_tready", cfg_if.cfg_tready, 0);
        check("w_hold", core_hold, 1);
        check("w_swap", swap_done, 0);
        check("w_bank", bank_sel, 0);
        read_chk("w_old0", 0, 0);
        tick();
        check("s_swap", swap_done, 1);
        check("s_hold", core_hold, 1);
        check("s_tready", cfg_if.cfg_tready, 0);
        check("s_bank", bank_sel, 0);
        tick();
        check("a_swap", swap_done, 0);
        check("a_bank", bank_sel, 1);
        check("a_tready", cfg_if.cfg_tready, 1);
        check("a_hold", core_hold, 0);
        read_chk("a_rd0", 0, -35);
        read_chk("a_rd70", 70, 35);
        tick();

        // Swap deferred while the erode core is busy.
        busy_erode = 1'b1;
        for (int k = 0; k < int'(Kw); k++) begin
            beat(100 - k, k == int'(Kw) - 1);
        end
        for (int i = 0; i < 20; i++) begin
            check("bz_hold", core_hold, 1);
            check("bz_tready", cfg_if.cfg_tready, 0);
            check("bz_bank", bank_sel, 1);
            check("bz_swap", swap_done, 0);
            tick();
        end
        busy_erode = 1'b0;
        check("bz_fall_swap", swap_done, 0);
        tick();
        check("bz_swap_now", swap_done, 1);
        tick();
        check("bz_bank_new", bank_sel, 0);
        read_chk("bz_rd0", 0, 100);
        read_chk("bz_rd5", 5, 95);
        read_chk("bz_rd70", 70, 30);
        tick();

        // Early tlast on beat 10 flags an error and keeps the old bank.
        for (int k = 0; k <= 10; k++) begin
            beat(7, k == 10);
        end
        check("e_err", cfg_error, 1);
        check("e_tready", cfg_if.cfg_tready, 1);
        check("e_hold", core_hold, 0);
        tick();
        check("e_swap", swap_done, 0);
        check("e_bank", bank_sel, 0);
        read_chk("e_rd3", 3, 97);
        tick();
        load_ramp();
        check("e_err_wait", cfg_error, 1);
        tick();
        check("e_swap2", swap_done, 1);
        tick();
        check("e_err_clr", cfg_error, 0);
        check("e_bank2", bank_sel, 1);
        read_chk("e_rd10", 10, -25);
        tick();

        // 72 beats without tlast: error at beat 71, beat 72 lands at index 0.
        for (int j = 0; j < 72; j++) begin
            beat(20 + j, 1'b0);
            if (j == 70) check("ov_err", cfg_error, 1);
        end
        check("ov_tready", cfg_if.cfg_tready, 1);
        check("ov_bank", bank_sel, 1);
        read_chk("ov_rd0", 0, -35);
        tick();
        for (int k = 1; k < int'(Kw); k++) begin
            beat(-k, k == int'(Kw) - 1);
        end
        check("ov_w_tready", cfg_if.cfg_tready, 0);
        tick();
        check("ov_swap", swap_done, 1);
        tick();
        check("ov_bank2", bank_sel, 0);
        check("ov_err_clr", cfg_error, 0);
        read_chk("ov_rd0b", 0, 91);
        read_chk("ov_rd1", 1, -1);
        read_chk("ov_rd70", 70, -70);
        tick();

        // Two ports, one out of range, in the same cycle.
        ero_addr = 7'd80;
        dil_addr = 7'd3;
        #1;
        check("oor_ero80", ero_data, 0);
        check("oor_dil3", dil_data, -3);
        ero_addr = 7'd71;
        dil_addr = 7'd70;
        #1;
        check("oor_ero71", ero_data, 0);
        check("oor_dil70", dil_data, -70);
        ero_addr = 7'd127;
        dil_addr = 7'd0;
        #1;
        check("oor_ero127", ero_data, 0);
        check("oor_dil0", dil_data, 91);
        tick();

        // Reset while waiting for idle cancels the pending swap.
        busy_dilate = 1'b1;
        load_ramp();
        check("rw_tready", cfg_if.cfg_tready, 0);
        check("rw_hold", core_hold, 1);
        reset = 1'b1;
        tick();
        check("rw_bank", bank_sel, 0);
        check("rw_swap", swap_done, 0);
        check("rw_tready2", cfg_if.cfg_tready, 1);
        check("rw_hold2", core_hold, 0);
        check("rw_err", cfg_error, 0);
        read_chk("rw_rd0", 0, 0);
        read_chk("rw_rd3", 3, 0);
        reset       = 1'b0;
        busy_dilate = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rw_post_swap", swap_done, 0);
            check("rw_post_bank", bank_sel, 0);
            check("rw_post_tready", cfg_if.cfg_tready, 1);
        end

        // Reset landing on the swap cycle suppresses swap_done and the toggle.
        load_ramp();
        tick();
        check("rs_swap_pre", swap_done, 1);
        reset = 1'b1;
        #1;
        check("rs_swap_masked", swap_done, 0);
        tick();
        check("rs_bank", bank_sel, 0);
        read_chk("rs_rd0", 0, 0);
        reset = 1'b0;
        tick();
        check("rs_bank2", bank_sel, 0);
        check("rs_swap2", swap_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
